mod_counter: RTL and testbench

Parametrised synchronous up/down counter. Successor to the fixed 4-bit enable counter, with programmable width, modulus, wrap or saturate mode, a built-in enable prescaler, synchronous load/clear, a terminal-count pulse and a sticky overflow flag. Used as the general-purpose event, timeout and divider counter in datapath and control blocks. Also serves as the DUT for the next generation of auto-generated benches.

---
 rtl/mod_counter_pkg.sv | 20 ++
 rtl/mod_counter_prescale.sv | 29 ++
 rtl/mod_counter.sv | 113 +++++++++++
 tb/tb_mod_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the mod_counter family.
package mod_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input longint unsigned n);
    int unsigned     r;
    longint unsigned v;
    r = 0;
    v = 64'd1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Enable prescaler: emits tick on every PRESCALE-th enabled cycle.
module mod_counter_prescale
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned     PW   = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = enable && (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pcnt <= '0;
    end else if (enable) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with prescaler, load/clear,
// terminal-count pulse and sticky overflow.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     SATURATE = MODE_WRAP,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "mod_counter: MODULUS must be 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $fatal(1, "mod_counter: PRESCALE must be 1..65536");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $fatal(1, "mod_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 64'd1);

  logic             tick;
  logic             restart;
  logic             step;
  logic             boundary;
  logic [WIDTH:0]   cur;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_clamped;

  assign restart    = clear | load;
  assign step       = tick & ~restart;
  assign cur        = {1'b0, count};
  assign ld_clamped = ({1'b0, load_val} > MAXV) ? WIDTH'(MAXV) : load_val;

  mod_counter_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    boundary = 1'b0;
    nxt      = count;
    if (up_dn) begin
      if (cur == MAXV) begin
        boundary = 1'b1;
        nxt      = (SATURATE == MODE_SAT) ? WIDTH'(MAXV) : '0;
      end else begin
        nxt = WIDTH'(cur + (WIDTH+1)'(1));
      end
    end else begin
      if (cur == '0) begin
        boundary = 1'b1;
        nxt      = (SATURATE == MODE_SAT) ? '0 : WIDTH'(MAXV);
      end else begin
        nxt = WIDTH'(cur - (WIDTH+1)'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= ld_clamped;
    end else if (step) begin
      count <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc <= 1'b0;
    end else begin
      tc <= step & boundary;
    end
  end

  // A boundary on the same edge as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (step && boundary) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three instances (wrap/16, sat/10, wrap/10 prescale 3).
module tb_mod_counter;

  typedef struct {
    int         sel;
    logic       rst, en, ud, clr, ld, oc;
    logic [3:0] lv;
    logic [3:0] ec;
    logic       et, eo;
  } vec_t;

  typedef struct {
    int         idx;
    int         sel;
    logic [3:0] ec;
    logic       et, eo;
  } exp_t;

  logic       clk;
  logic       rst [3];
  logic       en  [3];
  logic       ud  [3];
  logic       clr [3];
  logic       ld  [3];
  logic       oc  [3];
  logic [3:0] lv  [3];
  logic [3:0] cnt [3];
  logic       tco [3];
  logic       ovf [3];

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_a (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .up_dn(ud[0]), .clear(clr[0]),
    .load(ld[0]), .load_val(lv[0]), .ovf_clr(oc[0]),
    .count(cnt[0]), .tc(tco[0]), .overflow(ovf[0]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_b (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .up_dn(ud[1]), .clear(clr[1]),
    .load(ld[1]), .load_val(lv[1]), .ovf_clr(oc[1]),
    .count(cnt[1]), .tc(tco[1]), .overflow(ovf[1]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_c (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .up_dn(ud[2]), .clear(clr[2]),
    .load(ld[2]), .load_val(lv[2]), .ovf_clr(oc[2]),
    .count(cnt[2]), .tc(tco[2]), .overflow(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel, reset, enable, up_dn, clear, load, load_val, ovf_clr -> count, tc, overflow
  task automatic v(input int sel, input logic r, input logic e, input logic u,
                   input logic c, input logic l, input int lval, input logic o,
                   input int xc, input logic xt, input logic xo);
    vec_t t;
    t.sel = sel; t.rst = r; t.en = e; t.ud = u; t.clr = c; t.ld = l;
    t.lv = 4'(lval); t.oc = o; t.ec = 4'(xc); t.et = xt; t.eo = xo;
    vecs.push_back(t);
  endtask

  task automatic build_vectors();
    // Instance A: default 4-bit wrap
    v(0, 1,0,0,0,0, 0,0,  0,0,0);
    v(0, 1,1,1,0,0, 0,0,  0,0,0);
    for (int k = 1; k <= 17; k++)
      v(0, 0,1,1,0,0, 0,0, k % 16, k == 16, k >= 16);
    v(0, 0,0,1,0,1, 15,0, 15,0,1);
    v(0, 0,1,1,0,1, 5,0,  5,0,1);   // load beats tick at terminal count
    v(0, 0,1,1,1,1, 9,0,  0,0,1);   // clear beats load
    v(0, 0,0,1,0,0, 0,1,  0,0,0);
    v(0, 0,1,0,0,0, 0,1,  15,1,1);  // boundary beats ovf_clr
    v(0, 0,0,0,0,0, 0,0,  15,0,1);
    v(0, 1,1,1,0,1, 3,0,  0,0,0);
    // Instance B: modulus 10 saturate
    v(1, 1,0,0,0,0, 0,0,  0,0,0);
    v(1, 0,0,1,0,1, 8,0,  8,0,0);
    v(1, 0,1,1,0,0, 0,0,  9,0,0);
    v(1, 0,1,1,0,0, 0,0,  9,1,1);
    v(1, 0,1,1,0,0, 0,0,  9,1,1);
    v(1, 0,1,1,0,0, 0,0,  9,1,1);
    v(1, 0,0,1,0,0, 0,0,  9,0,1);
    v(1, 0,0,1,0,1, 12,0, 9,0,1);
    v(1, 0,0,1,0,1, 15,0, 9,0,1);
    v(1, 0,0,1,0,1, 0,0,  0,0,1);
    v(1, 0,1,0,0,0, 0,0,  0,1,1);
    v(1, 0,1,0,0,0, 0,0,  0,1,1);
    v(1, 0,0,0,0,0, 0,1,  0,0,0);
    v(1, 0,1,1,0,0, 0,0,  1,0,0);
    // Instance C: modulus 10 wrap, prescale 3
    v(2, 1,0,0,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  0,0,0);
    v(2, 0,0,1,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
    v(2, 0,1,1,0,0, 0,0,  2,0,0);
    v(2, 0,0,0,0,1, 0,0,  0,0,0);
    v(2, 0,1,0,0,0, 0,0,  0,0,0);
    v(2, 0,1,0,0,0, 0,0,  0,0,0);
    v(2, 0,1,0,0,0, 0,0,  9,1,1);
    v(2, 0,0,0,0,0, 0,1,  9,0,0);
    v(2, 0,1,1,0,0, 0,0,  9,0,0);   // direction flips mid-prescale
    v(2, 0,1,0,0,0, 0,0,  9,0,0);
    v(2, 0,1,0,0,0, 0,0,  8,0,0);
    v(2, 0,0,1,0,1, 9,0,  9,0,0);
    v(2, 0,1,1,0,0, 0,0,  9,0,0);
    v(2, 0,1,1,0,0, 0,0,  9,0,0);
    v(2, 0,1,1,0,0, 0,0,  0,1,1);
    v(2, 0,0,1,0,1, 7,0,  7,0,1);
    v(2, 0,1,1,0,0, 0,0,  7,0,1);
    v(2, 0,1,1,0,0, 0,0,  7,0,1);
    v(2, 1,1,1,0,0, 0,0,  0,0,0);   // reset with pcnt=2 pending tick
    v(2, 0,1,1,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
    v(2, 0,1,1,1,0, 0,0,  0,0,0);   // clear swallows tick and restarts prescaler
    v(2, 0,1,1,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  0,0,0);
    v(2, 0,1,1,0,0, 0,0,  1,0,0);
  endtask

  task automatic drive_idle();
    for (int unsigned i = 0; i < 3; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; ud[i] = 1'b0; clr[i] = 1'b0;
      ld[i] = 1'b0; oc[i] = 1'b0; lv[i] = '0;
    end
  endtask

  // Driver: apply one vector per cycle, enqueue expectation once the edge has captured it.
  initial begin
    exp_t e;
    drive_idle();
    build_vectors();
    for (int unsigned n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive_idle();
      rst[vecs[n].sel] = vecs[n].rst;
      en[vecs[n].sel]  = vecs[n].en;
      ud[vecs[n].sel]  = vecs[n].ud;
      clr[vecs[n].sel] = vecs[n].clr;
      ld[vecs[n].sel]  = vecs[n].ld;
      oc[vecs[n].sel]  = vecs[n].oc;
      lv[vecs[n].sel]  = vecs[n].lv;
      @(posedge clk);
      e.idx = int'(n); e.sel = vecs[n].sel;
      e.ec = vecs[n].ec; e.et = vecs[n].et; e.eo = vecs[n].eo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor: compare the selected instance's registered outputs away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (cnt[e.sel] === e.ec && tco[e.sel] === e.et && ovf[e.sel] === e.eo) begin
        n_pass++;
      end else begin
        $display("FAIL vec%0d inst%0d: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                 e.idx, e.sel, cnt[e.sel], tco[e.sel], ovf[e.sel], e.ec, e.et, e.eo);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
